riscv_v_pipe_ctrl: RTL and testbench

Sequencing controller for a shared-enable vector pipeline register chain of `NUM_STAGES` stages. It tracks per-stage valid bits alongside the data chain. It generates the chain's common `stage_en` and `stage_flush`, and exposes valid/ready handshakes at the input and output. It also supports a drain request so an upstream sequencer can quiesce the pipe before reconfiguration. It sits beside each multi-cycle vector datapath and drives the enable/flush pins of that datapath's stage chain.

---
 rtl/riscv_v_pkg.sv | 11 +
 rtl/riscv_v_pipe_ctrl.sv | 89 ++++++++
 tb/tb_riscv_v_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_v_pkg.sv
// Shared types for the vector pipeline sequencing controller.
// The state type is public so upstream sequencers can decode controller state.
package riscv_v_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } riscv_v_pipe_state_t;

endpackage

// File: rtl/riscv_v_pipe_ctrl.sv
// Valid-bit tracker and enable/flush generator for a shared-enable stage chain,
// with a drain sequence that lets an upstream sequencer quiesce the pipe.
module riscv_v_pipe_ctrl
   import riscv_v_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int OCC_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  flush_req,
   input  logic                  drain_req,
   output logic                  drain_done,
   output logic                  stage_en,
   output logic                  stage_flush,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic [OCC_W-1:0]      occupancy
);

   riscv_v_pipe_state_t   state_q;
   logic [NUM_STAGES-1:0] v_q;
   logic [NUM_STAGES-1:0] v_d;
   logic [OCC_W-1:0]      occ_q;
   logic [OCC_W-1:0]      occ_d;
   logic                  accept;
   logic                  emit;

   // The chain moves only when the tail is empty or being consumed, so bubbles collapse at the tail.
   assign stage_en    = !rst && !flush_req && (!v_q[NUM_STAGES-1] || out_ready);
   assign in_ready    = stage_en && (state_q == RUN);
   assign out_valid   = v_q[NUM_STAGES-1] && !flush_req && !rst;
   assign stage_flush = flush_req;
   assign drain_done  = (state_q == DONE) && !rst;
   assign stage_valid = v_q;
   assign occupancy   = occ_q;
   assign accept      = in_valid && in_ready;
   assign emit        = out_valid && out_ready;

   always_comb begin
      v_d   = v_q;
      occ_d = occ_q;
      if (flush_req) begin
         v_d   = '0;
         occ_d = '0;
      end else if (stage_en) begin
         v_d[0] = accept;
         for (int i = 1; i < NUM_STAGES; i++) begin
            v_d[i] = v_q[i-1];
         end
         case ({accept, emit})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end else begin
         v_d   = v_q;
         occ_d = occ_q;
      end
   end

   // A flush while draining counts as emptying the pipe, so DONE comes on the very next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         v_q     <= '0;
         occ_q   <= '0;
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
         case (state_q)
            RUN: begin
               if (drain_req && !flush_req) state_q <= DRAIN;
               else                         state_q <= RUN;
            end
            DRAIN: begin
               if (flush_req || (occ_q == '0)) state_q <= DONE;
               else                            state_q <= DRAIN;
            end
            DONE:    state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic checked every cycle against an array-based behavioural model.
module tb_riscv_v_pipe_ctrl;

   localparam int N  = 3;
   localparam int OW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          flush_req = 1'b0;
   logic          drain_req = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic          drain_done;
   logic          stage_en;
   logic          stage_flush;
   logic [N-1:0]  stage_valid;
   logic [OW-1:0] occupancy;

   int n_cmp = 0;
   int n_bad = 0;
   int dut_emit = 0;
   int dut_done = 0;
   int e0;
   int d0;

   // Model: one bit per stage (index 1 = first stage) and a mode number 0=run, 1=drain, 2=done.
   bit vm [1:N];
   int mode = 0;

   always #5 clk = ~clk;

   riscv_v_pipe_ctrl #(.NUM_STAGES(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .flush_req(flush_req),
      .drain_req(drain_req), .drain_done(drain_done), .stage_en(stage_en),
      .stage_flush(stage_flush), .stage_valid(stage_valid), .occupancy(occupancy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int m_occ();
      int c = 0;
      for (int i = 1; i <= N; i++) c += int'(vm[i]);
      return c;
   endfunction

   function automatic bit m_en();
      return !rst && !flush_req && (!vm[N] || out_ready);
   endfunction

   function automatic logic [N-1:0] m_sv();
      logic [N-1:0] s;
      for (int i = 1; i <= N; i++) s[i-1] = vm[i];
      return s;
   endfunction

   task automatic compare_all();
      bit en;
      en = m_en();
      chk("stage_en", 32'(stage_en), 32'(en));
      chk("in_ready", 32'(in_ready), 32'(en && mode == 0));
      chk("out_valid", 32'(out_valid), 32'(vm[N] && !flush_req && !rst));
      chk("stage_flush", 32'(stage_flush), 32'(flush_req));
      chk("drain_done", 32'(drain_done), 32'(mode == 2 && !rst));
      chk("stage_valid", 32'(stage_valid), 32'(m_sv()));
      chk("occupancy", 32'(occupancy), 32'(m_occ()));
      if (out_valid === 1'b1 && out_ready) dut_emit++;
      if (drain_done === 1'b1) dut_done++;
   endtask

   task automatic model_update();
      bit en;
      bit acc;
      int occ_now;
      if (rst) begin
         for (int i = 1; i <= N; i++) vm[i] = 1'b0;
         mode = 0;
      end else begin
         en      = m_en();
         acc     = en && mode == 0 && in_valid;
         occ_now = m_occ();
         if (flush_req) begin
            for (int i = 1; i <= N; i++) vm[i] = 1'b0;
         end else if (en) begin
            for (int i = N; i >= 2; i--) vm[i] = vm[i-1];
            vm[1] = acc;
         end
         case (mode)
            0:       if (drain_req && !flush_req) mode = 1;
            1:       if (flush_req || occ_now == 0) mode = 2;
            default: mode = 0;
         endcase
      end
   endtask

   task automatic step(input bit r, input bit iv, input bit ordy, input bit fl, input bit dr);
      @(posedge clk);
      model_update();
      #1;
      rst = r; in_valid = iv; out_ready = ordy; flush_req = fl; drain_req = dr;
      @(negedge clk);
      compare_all();
   endtask

   task automatic fill_stalled();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_stage_en", 32'(stage_en), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);

      // five beats streaming: A visible three cycles after acceptance
      e0 = dut_emit;
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1_c0_in_ready", 32'(in_ready), 32'd1);
      chk("t1_c0_out_valid", 32'(out_valid), 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1_c1_sv", 32'(stage_valid), 32'(3'b001));
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1_c2_sv", 32'(stage_valid), 32'(3'b011));
      chk("t1_c2_out_valid", 32'(out_valid), 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1_c3_out_valid", 32'(out_valid), 32'd1);
      chk("t1_c3_occ", 32'(occupancy), 32'd3);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1_c4_occ", 32'(occupancy), 32'd3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t1_c5_occ", 32'(occupancy), 32'd3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t1_c6_sv", 32'(stage_valid), 32'(3'b110));
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t1_c7_occ", 32'(occupancy), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t1_c8_occ", 32'(occupancy), 32'd0);
      chk("t1_emitted", 32'(dut_emit - e0), 32'd5);

      // backpressure on a full pipe
      fill_stalled();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         chk("t2_stage_en", 32'(stage_en), 32'd0);
         chk("t2_in_ready", 32'(in_ready), 32'd0);
         chk("t2_sv", 32'(stage_valid), 32'(3'b111));
         chk("t2_occ", 32'(occupancy), 32'd3);
      end
      e0 = dut_emit;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2_emitted", 32'(dut_emit - e0), 32'd3);
      chk("t2_occ_end", 32'(occupancy), 32'd0);

      // flush with two beats in flight and a beat offered
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t3_flush", 32'(stage_flush), 32'd1);
      chk("t3_out_valid", 32'(out_valid), 32'd0);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_occ_pre", 32'(occupancy), 32'd2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_sv", 32'(stage_valid), 32'd0);
      chk("t3_occ", 32'(occupancy), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_not_accepted", 32'(occupancy), 32'd0);

      // drain from occupancy 2
      d0 = dut_done;
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t4_occ2", 32'(occupancy), 32'd2);
      chk("t4_ready_run", 32'(in_ready), 32'd1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_ready_drain", 32'(in_ready), 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_occ1", 32'(occupancy), 32'd1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_occ0", 32'(occupancy), 32'd0);
      chk("t4_done_early", 32'(drain_done), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_done", 32'(drain_done), 32'd1);
      chk("t4_ready_done", 32'(in_ready), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_done_off", 32'(drain_done), 32'd0);
      chk("t4_ready_back", 32'(in_ready), 32'd1);
      chk("t4_pulses", 32'(dut_done - d0), 32'd1);

      // drain stalled by backpressure, ended by a flush
      d0 = dut_done;
      fill_stalled();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_occ", 32'(occupancy), 32'd3);
      chk("t5_ready", 32'(in_ready), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_flush", 32'(stage_flush), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_done", 32'(drain_done), 32'd1);
      chk("t5_occ0", 32'(occupancy), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_ready_back", 32'(in_ready), 32'd1);
      chk("t5_pulses", 32'(dut_done - d0), 32'd1);

      // reset in the middle of a drain at occupancy 3
      d0 = dut_done;
      fill_stalled();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_occ", 32'(occupancy), 32'd0);
      chk("t6_ready", 32'(in_ready), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_no_done", 32'(dut_done - d0), 32'd0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         bit r, iv, ordy, fl, dr;
         r    = ($urandom_range(0, 199) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 39) == 0);
         dr   = !fl && ($urandom_range(0, 29) == 0);
         step(r, iv, ordy, fl, dr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
